// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: issues one memory read per fetch request,
// waits (bounded) for read data, then strobes the word into the IR.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_load_val,
  input  logic        fault_clear,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] RD,
  output logic [31:0] PC,
  output logic        IRWrite,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam int unsigned      CNT_W   = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, PC, instruction word and wait counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; PC only moves on redirect in IDLE or after a capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          pc_d = pc_load_val;
        end else if (fetch_start) begin
          // A misaligned PC faults before any memory traffic is generated
          state_d = (pc_q[1:0] != 2'b00) ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          rd_d    = mem_rdata;
          state_d = S_CAPT;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPT: begin
        pc_d    = pc_q + 32'd4;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode registered state only, never same-cycle inputs
  assign mem_req  = (state_q == S_REQ) || (state_q == S_WAIT);
  assign IRWrite  = (state_q == S_CAPT);
  assign done     = (state_q == S_CAPT);
  assign busy     = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault    = (state_q == S_FAULT);
  assign mem_addr = pc_q;
  assign PC       = pc_q;
  assign RD       = rd_q;

endmodule
